// File: rtl/alu_seq_if.sv
// alu_seq_if: keypad/operator pulses, ALU operand/result bus and status of alu_seq_ctrl
interface alu_seq_if;
  logic        key_valid;
  logic [3:0]  key_data;
  logic        op_valid;
  logic [3:0]  op_code;
  logic        eq_valid;
  logic        clr;
  logic [31:0] alu_result;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [3:0]  alu_op;
  logic [31:0] result_q;
  logic [15:0] disp;
  logic        busy;
  logic        done;
  logic        err;
  logic        ovf;
  logic [2:0]  state;
  modport master (
    output key_valid, key_data, op_valid, op_code, eq_valid, clr, alu_result,
    input  op_a, op_b, alu_op, result_q, disp, busy, done, err, ovf, state
  );
  modport slave (
    input  key_valid, key_data, op_valid, op_code, eq_valid, clr, alu_result,
    output op_a, op_b, alu_op, result_q, disp, busy, done, err, ovf, state
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: calculator sequencer collecting hex operands, driving an external ALU and showing the result
module alu_seq_ctrl #(
  parameter int ALU_LAT = 2
) (
  input logic clk,
  input logic rst_n,
  alu_seq_if.slave bus
);
  localparam logic [2:0] ENTRY_A = 3'd0;
  localparam logic [2:0] ENTRY_B = 3'd1;
  localparam logic [2:0] EXEC    = 3'd2;
  localparam logic [2:0] SHOW    = 3'd3;
  localparam logic [2:0] ERROR   = 3'd4;
  localparam logic [3:0] DIV     = 4'd3;
  logic [2:0]  state;
  logic [15:0] acc, op_a, op_b;
  logic [3:0]  alu_op, cnt;
  logic [31:0] result_q;
  logic        done;
  logic        op_ok;
  assign op_ok = bus.op_valid && bus.op_code >= 4'd1 && bus.op_code <= 4'd4;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ENTRY_A;
      acc      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      alu_op   <= '0;
      result_q <= '0;
      cnt      <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.clr) begin
        state    <= ENTRY_A;
        acc      <= '0;
        op_a     <= '0;
        op_b     <= '0;
        alu_op   <= '0;
        result_q <= '0;
        cnt      <= '0;
      end else begin
        case (state)
          ENTRY_A: begin
            if (op_ok) begin
              op_a   <= acc;
              alu_op <= bus.op_code;
              acc    <= '0;
              state  <= ENTRY_B;
            end else if (bus.key_valid) acc <= {acc[11:0], bus.key_data};
          end
          ENTRY_B: begin
            if (bus.eq_valid) begin
              op_b  <= acc;
              cnt   <= '0;
              state <= (alu_op == DIV && acc == '0) ? ERROR : EXEC;
            end else if (op_ok) alu_op <= bus.op_code;
            else if (bus.key_valid) acc <= {acc[11:0], bus.key_data};
          end
          EXEC: begin
            if (cnt == 4'(ALU_LAT - 1)) begin
              result_q <= bus.alu_result;
              done     <= 1'b1;
              state    <= SHOW;
            end else cnt <= cnt + 4'd1;
          end
          SHOW: begin
            // eq repeats the last operation with the previous result as the new A
            if (bus.eq_valid) begin
              op_a  <= result_q[15:0];
              cnt   <= '0;
              state <= EXEC;
            end else if (op_ok) begin
              op_a   <= result_q[15:0];
              alu_op <= bus.op_code;
              acc    <= '0;
              state  <= ENTRY_B;
            end else if (bus.key_valid) begin
              acc   <= {12'd0, bus.key_data};
              state <= ENTRY_A;
            end
          end
          ERROR: begin
            if (bus.key_valid) begin
              acc   <= {12'd0, bus.key_data};
              state <= ENTRY_A;
            end
          end
          default: state <= ENTRY_A;
        endcase
      end
    end
  end
  assign bus.state    = state;
  assign bus.op_a     = op_a;
  assign bus.op_b     = op_b;
  assign bus.alu_op   = alu_op;
  assign bus.result_q = result_q;
  assign bus.done     = done;
  assign bus.busy     = state == EXEC;
  assign bus.err      = state == ERROR;
  assign bus.ovf      = state == SHOW && |result_q[31:16];
  assign bus.disp     = state == SHOW ? result_q[15:0] : state == ERROR ? 16'hEEEE : acc;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed and randomized checks of alu_seq_ctrl against a calculator model
module tb_alu_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  alu_seq_if b ();
  alu_seq_if b5 ();
  alu_seq_ctrl #(.ALU_LAT(2)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  alu_seq_ctrl #(.ALU_LAT(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));
  assign b5.key_valid  = b.key_valid;
  assign b5.key_data   = b.key_data;
  assign b5.op_valid   = b.op_valid;
  assign b5.op_code    = b.op_code;
  assign b5.eq_valid   = b.eq_valid;
  assign b5.clr        = b.clr;
  assign b5.alu_result = b.alu_result;
  always #5 clk = ~clk;

  task automatic pulse(input logic k, input logic [3:0] d, input logic o, input logic [3:0] oc,
                       input logic e, input logic c);
    @(negedge clk);
    b.key_valid = k; b.key_data = d; b.op_valid = o; b.op_code = oc; b.eq_valid = e; b.clr = c;
    @(negedge clk);
    b.key_valid = 0; b.op_valid = 0; b.eq_valid = 0; b.clr = 0;
  endtask
  task automatic key(input logic [3:0] d); pulse(1, d, 0, 0, 0, 0); endtask
  task automatic op(input logic [3:0] oc); pulse(0, 0, 1, oc, 0, 0); endtask
  task automatic eq(); pulse(0, 0, 0, 0, 1, 0); endtask
  task automatic clear(); pulse(0, 0, 0, 0, 0, 1); endtask
  task automatic wait_busy(output int n);
    n = 0;
    while (b.busy && n < 40) begin n++; @(negedge clk); end
  endtask

  task automatic test_reset();
    #12;
    total++; if (b.state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", b.state); end
    total++; if ({b.op_a, b.op_b, b.alu_op, b.result_q, b.disp} !== 84'd0) begin bad++;
      $display("FAIL reset_regs got=%h/%h/%h/%h/%h want=0", b.op_a, b.op_b, b.alu_op, b.result_q, b.disp); end
    total++; if ({b.busy, b.done, b.err, b.ovf} !== 4'b0) begin bad++;
      $display("FAIL reset_flags got=%b want=0000", {b.busy, b.done, b.err, b.ovf}); end
    @(negedge clk); rst_n = 1;
    @(negedge clk); @(negedge clk);
    total++; if (b.state !== 3'd0) begin bad++; $display("FAIL reset_idle got=%0d want=0", b.state); end
  endtask

  task automatic test_basic();
    int n;
    clear(); key(1); key(2); op(1); key(3); key(4);
    b.alu_result = 32'h46; eq();
    total++; if ({b.op_a, b.op_b, b.alu_op} !== {16'h12, 16'h34, 4'd1}) begin bad++;
      $display("FAIL basic_operands got=%h/%h/%h want=12/34/1", b.op_a, b.op_b, b.alu_op); end
    wait_busy(n);
    total++; if (n !== 2) begin bad++; $display("FAIL basic_busy got=%0d want=2", n); end
    total++; if (b.done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b want=1", b.done); end
    total++; if ({b.result_q, b.disp, b.ovf, b.state} !== {32'h46, 16'h46, 1'b0, 3'd3}) begin bad++;
      $display("FAIL basic_result got=%h/%h/%b/%0d want=46/0046/0/3", b.result_q, b.disp, b.ovf, b.state); end
    @(negedge clk);
    total++; if (b.done !== 1'b0) begin bad++; $display("FAIL basic_done_once got=%b want=0", b.done); end
  endtask

  task automatic test_div0();
    int busy_seen = 0;
    clear(); key(1); key(0); op(3); eq();
    for (int i = 0; i < 4; i++) begin busy_seen += int'(b.busy); @(negedge clk); end
    total++; if ({b.state, b.err, b.disp} !== {3'd4, 1'b1, 16'hEEEE}) begin bad++;
      $display("FAIL div0_error got=%0d/%b/%h want=4/1/eeee", b.state, b.err, b.disp); end
    total++; if (busy_seen !== 0) begin bad++; $display("FAIL div0_busy got=%0d want=0", busy_seen); end
    op(1); eq();
    total++; if (b.state !== 3'd4) begin bad++; $display("FAIL div0_ignore got=%0d want=4", b.state); end
    key(5);
    total++; if ({b.state, b.disp, b.err} !== {3'd0, 16'h5, 1'b0}) begin bad++;
      $display("FAIL div0_exit got=%0d/%h/%b want=0/0005/0", b.state, b.disp, b.err); end
  endtask

  task automatic test_wrap();
    clear();
    for (int i = 1; i <= 5; i++) key(4'(i));
    total++; if (b.disp !== 16'h2345) begin bad++; $display("FAIL wrap_disp got=%h want=2345", b.disp); end
    op(7);
    total++; if ({b.state, b.disp, b.op_a, b.alu_op} !== {3'd0, 16'h2345, 16'h0, 4'd0}) begin bad++;
      $display("FAIL wrap_badop got=%0d/%h/%h/%h want=0/2345/0/0", b.state, b.disp, b.op_a, b.alu_op); end
  endtask

  task automatic test_chain();
    int n;
    clear(); key(1); key(2); op(1); key(3); key(4);
    b.alu_result = 32'h46; eq(); wait_busy(n);
    op(4); key(2);
    b.alu_result = 32'h8C; eq();
    total++; if ({b.op_a, b.op_b, b.alu_op, b.state} !== {16'h46, 16'h2, 4'd4, 3'd2}) begin bad++;
      $display("FAIL chain_operands got=%h/%h/%h/%0d want=46/2/4/2", b.op_a, b.op_b, b.alu_op, b.state); end
    wait_busy(n);
    total++; if (b.result_q !== 32'h8C) begin bad++; $display("FAIL chain_result got=%h want=8c", b.result_q); end
    b.alu_result = 32'h118; eq();
    total++; if ({b.op_a, b.op_b, b.alu_op, b.state} !== {16'h8C, 16'h2, 4'd4, 3'd2}) begin bad++;
      $display("FAIL chain_repeat got=%h/%h/%h/%0d want=8c/2/4/2", b.op_a, b.op_b, b.alu_op, b.state); end
    wait_busy(n);
    total++; if ({b.result_q, b.disp} !== {32'h118, 16'h118}) begin bad++;
      $display("FAIL chain_repeat_res got=%h/%h want=118/0118", b.result_q, b.disp); end
    key(7);
    total++; if ({b.state, b.disp} !== {3'd0, 16'h7}) begin bad++;
      $display("FAIL chain_newkey got=%0d/%h want=0/0007", b.state, b.disp); end
  endtask

  task automatic test_clr();
    int n;
    int done_seen = 0;
    clear(); key(9); op(1); key(1);
    b.alu_result = 32'h1234_00AA; eq(); wait_busy(n);
    op(1); key(2);
    pulse(0, 0, 0, 0, 1, 1);
    total++; if ({b.state, b.op_a, b.op_b, b.alu_op, b.result_q, b.disp} !== 87'd0) begin bad++;
      $display("FAIL clr_eq got=%0d/%h/%h/%h/%h/%h want=all 0", b.state, b.op_a, b.op_b, b.alu_op, b.result_q, b.disp); end
    key(1); op(1); key(2);
    b.alu_result = 32'h3; eq(); clear();
    for (int i = 0; i < 6; i++) begin done_seen += int'(b.done); @(negedge clk); end
    total++; if ({b.state, b.result_q, b.busy} !== {3'd0, 32'h0, 1'b0}) begin bad++;
      $display("FAIL clr_exec got=%0d/%h/%b want=0/0/0", b.state, b.result_q, b.busy); end
    total++; if (done_seen !== 0) begin bad++; $display("FAIL clr_exec_done got=%0d want=0", done_seen); end
  endtask

  task automatic test_sub_lat5();
    int n2 = 0;
    int n5 = 0;
    clear(); key(5); op(2); key(7);
    b.alu_result = 32'hFFFF_FFFE; eq();
    for (int i = 0; i < 10; i++) begin n2 += int'(b.busy); n5 += int'(b5.busy); @(negedge clk); end
    total++; if (n2 !== 2) begin bad++; $display("FAIL lat2_busy got=%0d want=2", n2); end
    total++; if (n5 !== 5) begin bad++; $display("FAIL lat5_busy got=%0d want=5", n5); end
    total++; if ({b.result_q, b.disp, b.ovf} !== {32'hFFFF_FFFE, 16'hFFFE, 1'b1}) begin bad++;
      $display("FAIL sub_ovf got=%h/%h/%b want=fffffffe/fffe/1", b.result_q, b.disp, b.ovf); end
    total++; if ({b5.result_q, b5.ovf, b5.state} !== {32'hFFFF_FFFE, 1'b1, 3'd3}) begin bad++;
      $display("FAIL lat5_result got=%h/%b/%0d want=fffffffe/1/3", b5.result_q, b5.ovf, b5.state); end
  endtask

  task automatic test_random();
    int n, nd;
    logic [15:0] a, bv;
    logic [3:0] o, d;
    logic [31:0] r;
    for (int it = 0; it < 25; it++) begin
      clear();
      a = 0;
      nd = $urandom_range(1, 6);
      for (int i = 0; i < nd; i++) begin
        d = 4'($urandom_range(0, 15));
        key(d);
        a = 16'(((32'(a) * 16) + 32'(d)) % 65536);
        if ($urandom_range(0, 3) == 0) op($urandom_range(0, 1) == 0 ? 4'd0 : 4'($urandom_range(5, 15)));
      end
      o = 4'($urandom_range(1, 4));
      op(o);
      total++; if ({b.state, b.op_a, b.alu_op, b.disp} !== {3'd1, a, o, 16'h0}) begin bad++;
        $display("FAIL rnd_opA it=%0d got=%0d/%h/%h/%h want=1/%h/%h/0", it, b.state, b.op_a, b.alu_op, b.disp, a, o); end
      bv = 0;
      if (o == 4'd3 && $urandom_range(0, 2) == 0) key(0);
      else begin
        nd = $urandom_range(1, 5);
        for (int i = 0; i < nd; i++) begin
          d = 4'($urandom_range(0, 15));
          key(d);
          bv = 16'(((32'(bv) * 16) + 32'(d)) % 65536);
        end
      end
      r = $urandom;
      b.alu_result = r;
      eq();
      total++; if (b.op_b !== bv) begin bad++; $display("FAIL rnd_opB it=%0d got=%h want=%h", it, b.op_b, bv); end
      if (o == 4'd3 && bv == 0) begin
        total++; if ({b.state, b.err, b.disp} !== {3'd4, 1'b1, 16'hEEEE}) begin bad++;
          $display("FAIL rnd_div0 it=%0d got=%0d/%b/%h want=4/1/eeee", it, b.state, b.err, b.disp); end
      end else begin
        wait_busy(n);
        total++; if ({n[3:0], b.done, b.state, b.result_q, b.disp, b.ovf} !== {4'd2, 1'b1, 3'd3, r, r[15:0], r[31:16] != 0}) begin bad++;
          $display("FAIL rnd_exec it=%0d got=%0d/%b/%0d/%h/%h/%b want=2/1/3/%h/%h/%b",
                   it, n, b.done, b.state, b.result_q, b.disp, b.ovf, r, r[15:0], r[31:16] != 0); end
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    int done_seen = 0;
    clear(); key(3); op(1); key(4);
    b.alu_result = 32'h77; eq();
    #1 rst_n = 0;
    #1;
    total++; if ({b.state, b.busy, b.op_a, b.op_b} !== {3'd0, 1'b0, 32'h0}) begin bad++;
      $display("FAIL rst_async got=%0d/%b/%h/%h want=0/0/0/0", b.state, b.busy, b.op_a, b.op_b); end
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 5; i++) begin done_seen += int'(b.done); @(negedge clk); end
    total++; if ({b.state, b.result_q, done_seen[3:0]} !== {3'd0, 32'h0, 4'd0}) begin bad++;
      $display("FAIL rst_abort got=%0d/%h/%0d want=0/0/0", b.state, b.result_q, done_seen); end
  endtask

  initial begin
    b.key_valid = 0; b.key_data = 0; b.op_valid = 0; b.op_code = 0;
    b.eq_valid = 0; b.clr = 0; b.alu_result = 0;
    test_reset();
    test_basic();
    test_div0();
    test_wrap();
    test_chain();
    test_clr();
    test_sub_lat5();
    test_random();
    test_reset_mid_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
